// File: rtl/dvsd_mult_pkg.sv
// -----------------------------------------------------------------------------
// dvsd_mult_pkg
// Shared constants and helpers for the pipelined signed/unsigned multiplier.
//   WIDTH_MIN/WIDTH_MAX   : legal operand width range
//   STAGES_MIN/STAGES_MAX : legal pipeline latency range
//   bw_correction()       : Baugh-Wooley correction constant for a given width
// -----------------------------------------------------------------------------
package dvsd_mult_pkg;

  localparam int WIDTH_MIN  = 4;
  localparam int WIDTH_MAX  = 32;
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int PROD_MAX   = 2 * WIDTH_MAX;

  // Baugh-Wooley correction: +2^W and +2^(2W-1), taken modulo 2^(2W).
  // Returned at the widest product size; callers keep the low 2*W bits.
  function automatic logic [PROD_MAX-1:0] bw_correction(input int width);
    logic [PROD_MAX-1:0] one_v;
    logic [PROD_MAX-1:0] corr_v;
    one_v  = {{(PROD_MAX-1){1'b0}}, 1'b1};
    corr_v = (one_v << width) | (one_v << (2 * width - 1));
    return corr_v;
  endfunction

endpackage

// File: rtl/dvsd_csa_tree.sv
// -----------------------------------------------------------------------------
// dvsd_csa_tree
// Combinational partial-product generator and 3:2 carry-save reduction.
// The product is sum + carry (mod 2^(2*WIDTH)).
//   a, b  : WIDTH-bit operands
//   sgn   : 1 = two's-complement operands (Baugh-Wooley), 0 = unsigned
//   sum   : 2*WIDTH-bit carry-save sum vector
//   carry : 2*WIDTH-bit carry-save carry vector
// -----------------------------------------------------------------------------
module dvsd_csa_tree
  import dvsd_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic [2*WIDTH-1:0] sum,
  output logic [2*WIDTH-1:0] carry
);

  localparam int PW = 2 * WIDTH;
  localparam logic [PROD_MAX-1:0] CORR_FULL = bw_correction(WIDTH);
  localparam logic [PW-1:0]       CORR      = CORR_FULL[PW-1:0];

  // Running carry-save accumulator: row k holds the reduction of the
  // correction row plus partial-product rows 0..k-1.
  logic [WIDTH:0][PW-1:0] acc_sum_s;
  logic [WIDTH:0][PW-1:0] acc_carry_s;

  // The correction row seeds the accumulator only for signed operands.
  assign acc_sum_s[0]   = sgn ? CORR : {PW{1'b0}};
  assign acc_carry_s[0] = {PW{1'b0}};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
    // Row gi is b[gi] times a. In signed mode the MSB-column term
    // (a[W-1]&b[gi], gi<W-1) and the MSB-row terms (a[j]&b[W-1], j<W-1)
    // are complemented; the corner term a[W-1]&b[W-1] keeps its polarity.
    localparam logic [WIDTH-1:0] FLIP = (gi == WIDTH - 1) ?
                                        {1'b0, {(WIDTH-1){1'b1}}} :
                                        {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0] pp_s;
    logic [PW-1:0]    row_s;

    assign pp_s  = (a & {WIDTH{b[gi]}}) ^ (FLIP & {WIDTH{sgn}});
    assign row_s = {{WIDTH{1'b0}}, pp_s} << gi;

    // 3:2 compressor: carries out of the top bit wrap away modulo 2^(2W).
    assign acc_sum_s[gi+1]   = acc_sum_s[gi] ^ acc_carry_s[gi] ^ row_s;
    assign acc_carry_s[gi+1] = ((acc_sum_s[gi] & acc_carry_s[gi]) |
                                (acc_sum_s[gi] & row_s) |
                                (acc_carry_s[gi] & row_s)) << 1;
  end

  assign sum   = acc_sum_s[WIDTH];
  assign carry = acc_carry_s[WIDTH];

endmodule

// File: rtl/dvsd_mult_pipe.sv
// -----------------------------------------------------------------------------
// dvsd_mult_pipe
// Pipelined WIDTH x WIDTH multiplier with valid/ready handshakes and a
// per-transaction signed/unsigned select. Latency is STAGES cycles.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : a, b, sgn presented
//   in_ready   : operands accepted this cycle
//   a, b       : operands
//   sgn        : 1 = two's complement, 0 = unsigned
//   out_valid  : m holds a completed product
//   out_ready  : consumer takes m this cycle
//   m          : 2*WIDTH-bit product
//   busy       : any pipeline stage holds a valid entry
// -----------------------------------------------------------------------------
module dvsd_mult_pipe
  import dvsd_mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] m,
  output logic               busy
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_param_check
    $error("dvsd_mult_pipe: WIDTH or STAGES outside the legal range");
  end

  localparam int PW     = 2 * WIDTH;
  localparam int EW     = 2 * PW;
  localparam int VW     = STAGES - 1;
  localparam int PIPE_W = VW * EW;

  // One carry-save entry. The operand mode is already folded into sum/carry
  // by the stage-1 reduction, so each entry carries its own sgn result.
  typedef struct packed {
    logic [PW-1:0] sum;
    logic [PW-1:0] carry;
  } entry_t;

  logic              adv_s;
  logic [PW-1:0]     tree_sum_s;
  logic [PW-1:0]     tree_carry_s;
  entry_t            head_s;
  entry_t            tail_s;
  logic              tail_vld_s;

  // Stage 1 sits in the low slot; each advance shifts entries one slot up.
  logic [PIPE_W-1:0] pipe_q, pipe_d;
  logic [VW-1:0]     vld_q, vld_d;
  logic [PW-1:0]     m_q, m_d;
  logic              out_valid_q, out_valid_d;

  dvsd_csa_tree #(
    .WIDTH(WIDTH)
  ) u_csa_tree (
    .a    (a),
    .b    (b),
    .sgn  (sgn),
    .sum  (tree_sum_s),
    .carry(tree_carry_s)
  );

  // Single global advance: every stage moves unless the output is stalled.
  assign adv_s      = !out_valid_q || out_ready;
  assign in_ready   = adv_s && !rst;
  assign head_s     = {tree_sum_s, tree_carry_s};
  assign tail_s     = pipe_q[PIPE_W-1 -: EW];
  assign tail_vld_s = vld_q[VW-1];

  assign out_valid  = out_valid_q;
  assign m          = m_q;
  assign busy       = (|vld_q) || out_valid_q;

  // Next-state for all stages: shift on advance, otherwise hold everything.
  always_comb begin
    pipe_d      = pipe_q;
    vld_d       = vld_q;
    m_d         = m_q;
    out_valid_d = out_valid_q;
    if (adv_s) begin
      pipe_d      = PIPE_W'({pipe_q, head_s});
      vld_d       = VW'({vld_q, in_valid && in_ready});
      out_valid_d = tail_vld_s;
      if (tail_vld_s) begin
        m_d = tail_s.sum + tail_s.carry;
      end else begin
        m_d = m_q;
      end
    end else begin
      pipe_d      = pipe_q;
      vld_d       = vld_q;
      m_d         = m_q;
      out_valid_d = out_valid_q;
    end
  end

  // Stage registers with synchronous reset discarding all in-flight entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q      <= {PIPE_W{1'b0}};
      vld_q       <= {VW{1'b0}};
      m_q         <= {PW{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      pipe_q      <= pipe_d;
      vld_q       <= vld_d;
      m_q         <= m_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/dvsd_mult_pipe.md
DVSD_MULT_PIPE -- requirements
Module: dvsd_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 SHALL have parameter STAGES, default 2, pipeline latency in cycles; legal range 2..4.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning operands a, b and sgn are presented.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the operands this cycle.
REQ-007 SHALL have port a, input, WIDTH, multiplicand.
REQ-008 SHALL have port b, input, WIDTH, multiplier.
REQ-009 SHALL have port sgn, input, 1: 1 means two's-complement operands, 0 means unsigned; sampled per transaction.
REQ-010 SHALL have port out_valid, output, 1, meaning m holds a completed product.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer accepts m this cycle.
REQ-012 SHALL have port m, output, 2*WIDTH, the product.
REQ-013 SHALL have port busy, output, 1, high while any pipeline stage holds a valid entry.

Function
REQ-014 SHALL accept a transaction on a rising edge where in_valid and in_ready are both 1.
REQ-015 SHALL deliver the product on a rising edge where out_valid and out_ready are both 1.
REQ-016 SHALL drive in_ready combinationally as (!out_valid || out_ready) && !rst, using one global advance signal for all stages.
REQ-017 SHALL present each accepted transaction on m with out_valid=1 exactly STAGES cycles after acceptance, provided out_ready stays high.
REQ-018 SHALL sustain a throughput of one transaction per cycle when in_valid=1 and out_ready=1.
REQ-019 SHALL freeze every stage register, including its data and valid bit, when out_valid=1 and out_ready=0; data SHALL NOT be lost or duplicated.
REQ-020 SHALL hold m and out_valid stable until the handshake completes.
REQ-021 SHALL let a bubble (in_valid=0 at an advance) propagate as an invalid stage without affecting neighbouring entries.
REQ-022 SHALL compute m = a*b exactly in 2*WIDTH bits, with no truncation or overflow, for both sgn values.
REQ-023 SHALL, when sgn=1, form the partial products per Baugh-Wooley: complement the MSB-row and MSB-column terms and add correction constants at bit WIDTH and bit 2*WIDTH-1.
REQ-024 SHALL, in stage 1, generate the partial products and reduce them with 3:2 compressors to a registered sum/carry pair.
REQ-025 SHALL, in stage STAGES, resolve the sum/carry pair with a carry-propagate adder into the m register.
REQ-026 SHALL use intermediate stages (STAGES>2) as pure sum/carry/valid delay registers.
REQ-027 SHALL carry sgn with each entry so that mixed-mode back-to-back transactions are each computed correctly.
REQ-028 SHALL drive busy as the OR of all stage valid bits.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear all stage valid bits, out_valid, busy and m to 0 and discard in-flight entries.
REQ-030 SHALL ignore in_valid during reset; because in_ready=0 while rst=1, no transaction is accepted that cycle.
REQ-031 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-032 SHALL place the WIDTH/STAGES legal-range constants and the Baugh-Wooley correction-constant function in the shared package dvsd_mult_pkg.
REQ-033 SHALL implement the partial-product reduction as one combinational sub-module, dvsd_csa_tree (parameter WIDTH; outputs sum and carry, each 2*WIDTH bits), instantiated once.

Verification
REQ-034 SHALL cover the unsigned corner case: WIDTH=8, STAGES=2, sgn=0, a=0xFF, b=0xFF -> m=0xFE01 with out_valid 2 cycles after acceptance.
REQ-035 SHALL cover the signed corner cases: sgn=1, a=0x80, b=0x80 -> m=0x4000; and sgn=1, a=0xFF, b=0x01 -> m=0xFFFF.
REQ-036 SHALL cover back-pressure: stream 5 transactions with out_ready=0 for cycles 3..6 -> all 5 products emerge in order, none dropped or duplicated, in_ready=0 while stalled.
REQ-037 SHALL cover mixed mode: alternating sgn=0/1 with a=0xFF, b=0x02 back-to-back -> m alternates 0x01FE / 0xFFFE.
REQ-038 SHALL cover reset mid-operation: rst asserted with 2 entries in flight -> next cycle out_valid=0, busy=0, m=0, and no stale product is emitted afterwards.
REQ-039 SHALL cover parametrisation: WIDTH=16, STAGES=4, 1000 random signed/unsigned pairs -> m matches the reference a*b with a fixed latency of 4 cycles.
